// File: rtl/result_tx_unloader.sv
// Serialises the result matrix to the UART TX byte stream, MSB byte first.
// Optional two-byte frame header enabled by defining RESULT_TX_HDR_EN.
module result_tx_unloader #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS * COLS - 1);
`ifdef RESULT_TX_HDR_EN
  localparam logic [7:0] NE_B = 8'(ROWS * COLS);
`endif

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_D,
    SEND,
    NEXT,
    DONE_S
`ifdef RESULT_TX_HDR_EN
    ,HDR0
    ,HDR1
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BW-1:0]     b_q, b_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              start_q;
  logic              start_edge;

  assign start_edge = start & ~start_q;
  assign mem_addr   = idx_q;
  assign busy       = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      b_q     <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    b_d      = b_q;
    shreg_d  = shreg_q;
    busy_d   = busy_q;
    mem_read = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          idx_d  = '0;
          busy_d = 1'b1;
`ifdef RESULT_TX_HDR_EN
          state_d = HDR0;
`else
          state_d = READ;
`endif
        end
      end
`ifdef RESULT_TX_HDR_EN
      HDR0: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_d = HDR1;
      end
      HDR1: begin
        tx_valid = 1'b1;
        tx_data  = NE_B;
        if (tx_ready) state_d = READ;
      end
`endif
      READ: begin
        mem_read = 1'b1;
        state_d  = WAIT_D;
      end
      WAIT_D: begin
        shreg_d = mem_data;
        b_d     = '0;
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[DATA_W-1 -: 8];
        if (tx_ready) begin
          shreg_d = shreg_q << 8;
          if (b_q == LAST_B) begin
            state_d = NEXT;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE_S;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      DONE_S: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_tx_unloader.sv
// Self-checking bench for result_tx_unloader: directed frames plus
// randomized data and backpressure against a byte-stream reference model.
module tb_result_tx_unloader;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int NE     = ROWS * COLS;
  localparam int NB     = DATA_W / 8;
`ifdef RESULT_TX_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int BASE_LAT = NE * (3 + NB) + 1 + HDR;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [NE];
  logic [7:0]        exp_q[$];
  logic [7:0]        got_q[$];
  int                addr_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stalls = 0;
  int stab_err = 0;
  int rd_cnt = 0;
  int vcnt = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_b = 8'h00;

  result_tx_unloader #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read) begin
      if (int'(mem_addr) < NE) mem_data <= mem[mem_addr[1:0]];
      else mem_data <= 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (mem_read) begin
      addr_q.push_back(int'(mem_addr));
      rd_cnt++;
    end
    if (tx_valid) vcnt++;
    if (tx_valid && !tx_ready) stalls++;
    if (done) done_cnt++;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && !(tx_valid && tx_data == hold_b)) stab_err++;
      hold_pend = tx_valid && !tx_ready;
      hold_b = tx_data;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void build_exp();
    exp_q = {};
    if (HDR != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(NE));
    end
    for (int e = 0; e < NE; e++)
      for (int k = NB - 1; k >= 0; k--)
        exp_q.push_back(8'((mem[e] >> (8 * k)) & 'hFF));
  endfunction

  task automatic check_bytes(input string tag, input int b0);
    chk({tag, "_len"}, got_q.size() - b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b0 + i < got_q.size())
        chk($sformatf("%s_b%0d", tag, i), int'(got_q[b0 + i]), int'(exp_q[i]));
  endtask

  task automatic check_addrs(input string tag, input int a0);
    chk({tag, "_nrd"}, addr_q.size() - a0, NE);
    for (int i = 0; i < NE; i++)
      if (a0 + i < addr_q.size())
        chk($sformatf("%s_a%0d", tag, i), addr_q[a0 + i], i);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NE; i++) mem[i] = DATA_W'($urandom);
  endtask

  task automatic run_frame(input bit rnd, input int stall_at,
                           input int stall_len, input int abort_at,
                           output int lat, output int fv, output int stl);
    int n, left, b0, s0;
    b0 = got_q.size();
    s0 = stalls;
    lat = -1;
    fv = -1;
    stl = 0;
    left = stall_len;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    n = cyc;
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (fv < 0 && tx_valid) fv = cyc - n;
      if (done) begin
        lat = cyc - n;
        stl = stalls - s0;
        break;
      end
      if (abort_at >= 0 && got_q.size() - b0 == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk("abort_outs", int'({mem_read, mem_addr, tx_data,
                                   tx_valid, busy, done}), 0);
        start = 1'b0;
        cycle();
        rst_n = 1'b1;
        break;
      end
      if (stall_at >= 0 && got_q.size() - b0 == stall_at &&
          tx_valid && left > 0) begin
        tx_ready = 1'b0;
        left--;
        chk("stall_valid", int'(tx_valid), 1);
        chk("stall_data", int'(tx_data), int'(exp_q[stall_at]));
      end else begin
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  endtask

  initial begin
    int lat, fv, stl, b0, a0, d0;
    rst_n = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < NE; i++) mem[i] = '0;
    repeat (3) cycle();
    chk("reset_outs", int'({mem_read, mem_addr, tx_data,
                            tx_valid, busy, done}), 0);
    rst_n = 1'b1;
    repeat (10) cycle();
    chk("idle_no_read", rd_cnt, 0);
    chk("idle_no_valid", vcnt, 0);

    mem[0] = 16'h0013;
    mem[1] = 16'h0016;
    mem[2] = 16'h002B;
    mem[3] = 16'h0032;
    build_exp();
    b0 = got_q.size(); a0 = addr_q.size(); d0 = done_cnt;
    run_frame(1'b0, -1, 0, -1, lat, fv, stl);
    start = 1'b0;
    chk("basic_lat", lat, BASE_LAT);
    chk("basic_first_valid", fv, 3);
    cycle();
    chk("basic_busy_after", int'(busy), 0);
    chk("basic_done_cnt", done_cnt - d0, 1);
    check_bytes("basic", b0);
    check_addrs("basic", a0);

    repeat (3) cycle();
    b0 = got_q.size(); d0 = done_cnt;
    run_frame(1'b0, 2, 5, -1, lat, fv, stl);
    start = 1'b0;
    chk("bp_lat", lat, BASE_LAT + 5);
    check_bytes("bp", b0);
    cycle();
    chk("bp_done_cnt", done_cnt - d0, 1);

    repeat (3) cycle();
    rand_mem();
    build_exp();
    b0 = got_q.size(); d0 = done_cnt;
    run_frame(1'b0, -1, 0, -1, lat, fv, stl);
    repeat (100) cycle();
    chk("level_one_done", done_cnt - d0, 1);
    check_bytes("level1", b0);
    start = 1'b0;
    repeat (3) cycle();
    rand_mem();
    build_exp();
    b0 = got_q.size();
    run_frame(1'b0, -1, 0, -1, lat, fv, stl);
    start = 1'b0;
    chk("level2_lat", lat, BASE_LAT);
    check_bytes("level2", b0);

    repeat (3) cycle();
    rand_mem();
    build_exp();
    d0 = done_cnt;
    run_frame(1'b0, -1, 0, 3, lat, fv, stl);
    repeat (5) cycle();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_busy", int'(busy), 0);
    b0 = got_q.size(); a0 = addr_q.size();
    run_frame(1'b0, -1, 0, -1, lat, fv, stl);
    start = 1'b0;
    chk("after_abort_lat", lat, BASE_LAT);
    check_bytes("after_abort", b0);
    check_addrs("after_abort", a0);

    for (int f = 0; f < 5; f++) begin
      repeat (2) cycle();
      rand_mem();
      build_exp();
      b0 = got_q.size();
      run_frame(1'b1, -1, 0, -1, lat, fv, stl);
      start = 1'b0;
      tx_ready = 1'b1;
      chk($sformatf("rnd%0d_lat", f), lat, BASE_LAT + stl);
      check_bytes($sformatf("rnd%0d", f), b0);
    end
    cycle();
    chk("handshake_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
